exec_data_queue_mc: RTL
=======================

EXEC_DATA_QUEUE_MC -- requirements
Module: exec_data_queue_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 32: input word width in bits.
REQ-002 SHALL have parameter SCALER, default 2: input words packed per output row, ≥1.
REQ-003 SHALL have parameter DEPTH, default 2048: rows per channel, power of 2.
REQ-004 SHALL have parameter CHANNELS, default 2: independent queues, power of 2, ≥1.
REQ-005 SHALL have parameter AFULL_THRESH, default DEPTH-16: almost_full level in rows.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port wr_en  in  1  write request.
REQ-009 SHALL have port wr_ch  in  CHW=max(1,clog2(CHANNELS))  write channel.
REQ-010 SHALL have port din  in  WIDTH  write word.
REQ-011 SHALL have port flush  in  1  commit the partial row of wr_ch.
REQ-012 SHALL have port rd_en  in  1  read request.
REQ-013 SHALL have port rd_ch  in  CHW  read channel.
REQ-014 SHALL have port dout  out  WIDTH*SCALER  read row.
REQ-015 SHALL have port data_valid  out  1  dout valid.
REQ-016 SHALL have port full, empty, almost_full  out  CHANNELS  per-channel flags.
REQ-017 SHALL have port rd_data_count  out  CHANNELS*(clog2(DEPTH)+1)  rows held per channel; channel 0 in the LSBs.
REQ-018 SHALL have port overflow, underflow  out  1  single-cycle error pulses.

Function
REQ-019 SHALL accept a write when wr_en=1 and full[wr_ch]=0; din SHALL go into the packer of wr_ch at slot pack_cnt[wr_ch]; word 0 SHALL occupy the LSBs.
REQ-020 SHALL commit the packer to the channel ring as one row when the accepted write fills slot SCALER-1; row_count SHALL update on the following edge.
REQ-021 SHALL, on flush=1 with pack_cnt[wr_ch]>0, or with a write accepted in the same cycle, zero-pad the unused slots and commit. Any word accepted in that cycle SHALL be included in the row.
REQ-022 SHALL ignore flush when the packer is empty and no write is accepted.
REQ-023 SHALL drive full[ch]=1 iff row_count[ch]==DEPTH, empty[ch]=1 iff row_count[ch]==0, and almost_full[ch]=1 iff row_count[ch]≥AFULL_THRESH.
REQ-024 SHALL pulse overflow for one cycle when wr_en=1 and full[wr_ch]=1; the word SHALL be dropped and no state SHALL change.
REQ-025 SHALL accept a read when rd_en=1 and empty[rd_ch]=0; dout and data_valid SHALL be registered, with 1-cycle latency.
REQ-026 SHALL pulse underflow for one cycle when rd_en=1 and empty[rd_ch]=1; data_valid SHALL be 0 the next cycle.
REQ-027 SHALL hold dout at its last value while data_valid=0.
REQ-028 SHALL handle a commit and a read on the same channel in the same cycle so that row_count is unchanged, pointers both advance, and data is preserved.
REQ-029 SHALL wrap per-channel read/write pointers modulo DEPTH; channels SHALL NOT interfere.
REQ-030 SHALL address a single shared simple-dual-port RAM of CHANNELS*DEPTH rows with address {ch, ptr}; at most one write and one read SHALL occur per cycle.
REQ-031 SHALL return the newly committed row when a read hits a row written in the same cycle on an empty-after-commit channel only after row_count≥1; empty SHALL be evaluated before the commit, so no read-during-write hazard occurs.

Reset
REQ-032 SHALL, on rst=1 asynchronously, clear all pointers, row counts, pack counts and packer contents to 0.
REQ-033 SHALL, on rst=1, drive dout=0, data_valid=0, overflow=0, underflow=0, full=0, almost_full=0, and empty=all 1s.
REQ-034 SHALL discard, on reset mid-operation, all stored rows and partial packers; RAM contents SHALL need no clearing.

Structure
REQ-035 SHALL take CHW, CNTW=clog2(DEPTH)+1, and default parameter values from shared package exec_dq_pkg.
REQ-036 SHALL place the storage in one sub-module, exec_dq_ram: parametrised simple-dual-port RAM with registered read and 1-cycle latency.
REQ-037 SHALL implement the packers, pointers, counts and flags in the top level, fully synchronous to clk.

Verification (WIDTH=32, SCALER=2, DEPTH=4, CHANNELS=2)
REQ-038 SHALL verify: write ch0 0x11, then 0x22; rd_en ch0 -> next cycle data_valid=1, dout=0x00000022_00000011, empty[0]=1.
REQ-039 SHALL verify: 8 writes to ch1 -> full[1]=1, almost_full[1]=1; a 9th write -> overflow pulse; empty[0] stays 1.
REQ-040 SHALL verify: write ch0 0xAA, then flush -> rd_data_count[0]=1; read returns 0x00000000_000000AA.
REQ-041 SHALL verify: rd_en on empty ch1 -> underflow pulse; data_valid=0; dout unchanged.
REQ-042 SHALL verify: ch0 holds 1 row, a row-completing write and a read occur in the same cycle -> count stays 1, and the rows come out in order.
REQ-043 SHALL verify: rst asserted with 3 rows and a half packer on ch0 -> all counts 0, empty=2'b11; the next write/flush/read returns only new data.

Source files
------------

// File: rtl/exec_dq_pkg.sv
// Shared defaults and width helpers for the multi-channel packing data queue.
package exec_dq_pkg;

  localparam int DQ_WIDTH    = 32;
  localparam int DQ_SCALER   = 2;
  localparam int DQ_DEPTH    = 2048;
  localparam int DQ_CHANNELS = 2;

  // Select width for n items; never narrower than one bit.
  function automatic int dq_chw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter width able to hold the value depth itself.
  function automatic int dq_cntw(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/exec_dq_ram.sv
// Simple-dual-port row storage: one write port, one registered read port.
// Only the read register is reset; array contents are never cleared.
module exec_dq_ram #(
  parameter int ROWW = 64,
  parameter int AW   = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [ROWW-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [ROWW-1:0] rdata
);

  logic [ROWW-1:0] mem [1 << AW];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; output holds its last value when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/exec_data_queue_mc.sv
// Multi-channel queue: per-channel word packers feed per-channel rings that
// share one simple-dual-port RAM addressed as {channel, pointer}.
module exec_data_queue_mc
  import exec_dq_pkg::*;
#(
  parameter int WIDTH        = DQ_WIDTH,
  parameter int SCALER       = DQ_SCALER,
  parameter int DEPTH        = DQ_DEPTH,
  parameter int CHANNELS     = DQ_CHANNELS,
  parameter int AFULL_THRESH = DEPTH - 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  wr_en,
  input  logic [dq_chw(CHANNELS)-1:0]           wr_ch,
  input  logic [WIDTH-1:0]                      din,
  input  logic                                  flush,
  input  logic                                  rd_en,
  input  logic [dq_chw(CHANNELS)-1:0]           rd_ch,
  output logic [WIDTH*SCALER-1:0]               dout,
  output logic                                  data_valid,
  output logic [CHANNELS-1:0]                   full,
  output logic [CHANNELS-1:0]                   empty,
  output logic [CHANNELS-1:0]                   almost_full,
  output logic [CHANNELS*dq_cntw(DEPTH)-1:0]    rd_data_count,
  output logic                                  overflow,
  output logic                                  underflow
);

  localparam int CHW  = dq_chw(CHANNELS);
  localparam int CNTW = dq_cntw(DEPTH);
  localparam int PTRW = CNTW - 1;
  localparam int PCW  = dq_chw(SCALER);
  localparam int ROWW = WIDTH * SCALER;

  logic [PTRW-1:0] wptr      [CHANNELS];
  logic [PTRW-1:0] rptr      [CHANNELS];
  logic [CNTW-1:0] row_count [CHANNELS];
  logic [PCW-1:0]  pack_cnt  [CHANNELS];
  logic [ROWW-1:0] pack_data [CHANNELS];

  logic            wr_ok, rd_ok, commit;
  logic [PCW-1:0]  cur_cnt;
  logic [ROWW-1:0] row_next;

  // Per-channel status flags and the flattened occupancy bus.
  always_comb begin
    full          = '0;
    empty         = '0;
    almost_full   = '0;
    rd_data_count = '0;
    for (int ch = 0; ch < CHANNELS; ch++) begin
      full[ch]        = (row_count[ch] == CNTW'(DEPTH));
      empty[ch]       = (row_count[ch] == '0);
      almost_full[ch] = (int'(row_count[ch]) >= AFULL_THRESH);
      rd_data_count[ch*CNTW +: CNTW] = row_count[ch];
    end
  end

  // Accept/commit decode; unused slots are already zero, which pads flushed rows.
  always_comb begin
    wr_ok    = wr_en & ~full[wr_ch];
    rd_ok    = rd_en & ~empty[rd_ch];
    cur_cnt  = pack_cnt[wr_ch];
    row_next = pack_data[wr_ch];
    if (wr_ok) row_next[int'(cur_cnt)*WIDTH +: WIDTH] = din;
    commit   = (wr_ok && (cur_cnt == PCW'(SCALER - 1))) ||
               (flush && !full[wr_ch] && ((cur_cnt != '0) || wr_ok));
  end

  // Packers, pointers, row counts and error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        wptr[ch]      <= '0;
        rptr[ch]      <= '0;
        row_count[ch] <= '0;
        pack_cnt[ch]  <= '0;
        pack_data[ch] <= '0;
      end
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if (wr_ch == CHW'(ch)) begin
          if (commit) begin
            pack_cnt[ch]  <= '0;
            pack_data[ch] <= '0;
            wptr[ch]      <= wptr[ch] + 1'b1;
          end else if (wr_ok) begin
            pack_cnt[ch]  <= cur_cnt + 1'b1;
            pack_data[ch] <= row_next;
          end
        end
        if (rd_ok && (rd_ch == CHW'(ch))) rptr[ch] <= rptr[ch] + 1'b1;
        case ({commit && (wr_ch == CHW'(ch)), rd_ok && (rd_ch == CHW'(ch))})
          2'b10:   row_count[ch] <= row_count[ch] + 1'b1;
          2'b01:   row_count[ch] <= row_count[ch] - 1'b1;
          default: row_count[ch] <= row_count[ch];
        endcase
      end
      data_valid <= rd_ok;
      overflow   <= wr_en & full[wr_ch];
      underflow  <= rd_en & empty[rd_ch];
    end
  end

  exec_dq_ram #(
    .ROWW (ROWW),
    .AW   (CHW + PTRW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (commit),
    .waddr ({wr_ch, wptr[wr_ch]}),
    .wdata (row_next),
    .re    (rd_ok),
    .raddr ({rd_ch, rptr[rd_ch]}),
    .rdata (dout)
  );

endmodule
